mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Memory-side responder to the pipeline's instruction and data request ports (i_mem_*, d_mem_*).
// - Arbitrates both ports onto a single physical memory port (pmem_*).
// - Returns a one-cycle i_mem_resp / d_mem_resp per completed transaction; this is the handshake
//   consumed by hazard_detection to generate its stall and load signals.
// - Sits between the pipeline datapath and the shared memory / L2.
// PARAMETERS
// - ADDR_WIDTH    16  byte address width (lc3b_word)
// - DATA_WIDTH    16  data width; the write mask is DATA_WIDTH/8 bits
// - STARVE_LIMIT  4   consecutive D grants, while I is waiting, before I is forced to win; range 1..15
// PORTS
// - clk            in   1   rising-edge clock
// - rst_n          in   1   asynchronous, active-low reset
// - i_mem_read     in   1   instruction fetch request; level, held until i_mem_resp
// - i_mem_address  in   AW  fetch address
// - i_mem_rdata    out  DW  fetch data; valid only while i_mem_resp=1
// - i_mem_resp     out  1   one-cycle fetch completion pulse
// - d_mem_read     in   1   data read request; level, held until d_mem_resp
// - d_mem_write    in   1   data write request; mutually exclusive with d_mem_read
// - d_mem_address  in   AW  data address
// - d_mem_wdata    in   DW  write data
// - d_mem_wmask    in   DW/8  byte enables for writes
// - d_mem_rdata    out  DW  read data; valid only while d_mem_resp=1
// - d_mem_resp     out  1   one-cycle data completion pulse
// - pmem_read      out  1   physical read strobe; held until pmem_resp
// - pmem_write     out  1   physical write strobe; held until pmem_resp
// - pmem_address   out  AW  physical address (registered)
// - pmem_wdata     out  DW  physical write data (registered)
// - pmem_wmask     out  DW/8  physical byte enables (registered)
// - pmem_rdata     in   DW  physical read data; valid with pmem_resp
// - pmem_resp      in   1   physical completion pulse
// BEHAVIOUR
// - Reset values:
//   - state=IDLE, starve_cnt=0, squash=0.
//   - Outputs: pmem_read/pmem_write/i_mem_resp/d_mem_resp=0; pmem_address/wdata/wmask=0.
// - States:
//   - IDLE: no transaction outstanding.
//   - I_BUSY: instruction fetch outstanding on pmem.
//   - D_BUSY: data read or write outstanding on pmem.
//   - TURN: one-cycle recovery after each transaction.
// - IDLE arbitration, evaluated every cycle:
//   - I request only -> I_BUSY.
//   - D request only -> D_BUSY.
//   - Both requesting: D wins unless starve_cnt==STARVE_LIMIT, in which case I wins.
//   - On grant, register address, wdata and wmask (wdata/wmask are 0 for reads) and the read/write type.
//   - pmem_read or pmem_write rises in the first cycle after the grant edge.
// - starve_cnt:
//   - Increments (saturating) on each D grant made while i_mem_read=1.
//   - Clears on any I grant, and on any D grant made while i_mem_read=0.
// - I_BUSY / D_BUSY:
//   - pmem strobes and registered fields stay constant until pmem_resp.
//   - On pmem_resp, go to TURN.
//   - In the same cycle, pulse the owner's *_resp and pass pmem_rdata through combinationally to its *_rdata.
// - Squash: if the owner deasserts its request while busy (pipeline redirect):
//   - Set squash.
//   - The pmem transaction still completes.
//   - The *_resp pulse is suppressed.
//   - squash clears on entering TURN.
// - Pending requests not yet granted may be withdrawn freely; nothing is issued for them.
// - TURN: all strobes low. Next cycle -> IDLE, so back-to-back requests are seen with fresh addresses.
// - Minimum latency from request in IDLE to *_resp is 2 cycles, when pmem_resp arrives 1 cycle after the strobe.
// - pmem_resp while IDLE or TURN is ignored; no *_resp is generated.
// - Both d_mem_read and d_mem_write high is illegal. The write is taken and a simulation assertion fires.
// - Asynchronous reset mid-transaction:
//   - Immediately returns to reset values.
//   - An outstanding pmem transaction is abandoned.
//   - A subsequent stray pmem_resp is ignored.
// TESTING
// - I only, addr 0x0010, pmem_resp 3 cycles after pmem_read, rdata 0x1234
//   -> i_mem_resp=1 for 1 cycle with i_mem_rdata=0x1234; TURN; IDLE.
// - D write, addr 0x0200, wdata 0xBEEF, wmask 2'b10
//   -> pmem_write with registered 0x0200/0xBEEF/2'b10; d_mem_resp 1 cycle; i_mem_resp stays 0.
// - I and D both held continuously, STARVE_LIMIT=4
//   -> grant order D,D,D,D,I,D,D,D,D,I; each owner sees exactly one resp per grant.
// - I granted, i_mem_read dropped 1 cycle later
//   -> pmem_read held until pmem_resp; no i_mem_resp pulse; next pending D granted after TURN.
// - rst_n low during D_BUSY, then pmem_resp arrives after release
//   -> all outputs 0 immediately; stray pmem_resp produces no *_resp.
// - pmem_resp pulsed in IDLE with no requests -> no resp outputs; state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Memory-side responder for the pipeline's instruction (i_mem_*) and data
//   (d_mem_*) request ports. Both ports share one physical memory port (pmem_*).
//   Each completed transaction produces a one-cycle *_resp pulse, which the
//   hazard unit turns into its stall/load controls.
//
//   Arbitration: data wins a tie unless the instruction port has been passed
//   over STARVE_LIMIT times in a row. Every transaction is followed by one
//   TURN cycle so that the next arbitration sees fresh request addresses.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   i_mem_read       fetch request (level, held until i_mem_resp)
//   i_mem_address    fetch address
//   i_mem_rdata      fetch data, meaningful only while i_mem_resp=1
//   i_mem_resp       one-cycle fetch completion
//   d_mem_read       data read request (level, held until d_mem_resp)
//   d_mem_write      data write request (never together with d_mem_read)
//   d_mem_address    data address
//   d_mem_wdata      write data
//   d_mem_wmask      write byte enables
//   d_mem_rdata      read data, meaningful only while d_mem_resp=1
//   d_mem_resp       one-cycle data completion
//   pmem_read/write  physical strobes, held until pmem_resp
//   pmem_address     registered physical address
//   pmem_wdata       registered physical write data (0 for reads)
//   pmem_wmask       registered physical byte enables (0 for reads)
//   pmem_rdata       physical read data, valid with pmem_resp
//   pmem_resp        physical completion pulse
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_mem_read,
   input  logic [ADDR_WIDTH-1:0]   i_mem_address,
   output logic [DATA_WIDTH-1:0]   i_mem_rdata,
   output logic                    i_mem_resp,
   input  logic                    d_mem_read,
   input  logic                    d_mem_write,
   input  logic [ADDR_WIDTH-1:0]   d_mem_address,
   input  logic [DATA_WIDTH-1:0]   d_mem_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_mem_wmask,
   output logic [DATA_WIDTH-1:0]   d_mem_rdata,
   output logic                    d_mem_resp,
   output logic                    pmem_read,
   output logic                    pmem_write,
   output logic [ADDR_WIDTH-1:0]   pmem_address,
   output logic [DATA_WIDTH-1:0]   pmem_wdata,
   output logic [DATA_WIDTH/8-1:0] pmem_wmask,
   input  logic [DATA_WIDTH-1:0]   pmem_rdata,
   input  logic                    pmem_resp
);

   localparam int MW = DATA_WIDTH / 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_I_BUSY = 2'd1;
   localparam logic [1:0] ST_D_BUSY = 2'd2;
   localparam logic [1:0] ST_TURN   = 2'd3;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic [1:0]            state_r;
   logic [3:0]            starve_cnt_r;
   logic                  squash_r;
   logic                  pmem_read_r;
   logic                  pmem_write_r;
   logic [ADDR_WIDTH-1:0] pmem_address_r;
   logic [DATA_WIDTH-1:0] pmem_wdata_r;
   logic [MW-1:0]         pmem_wmask_r;

   logic                  i_req_s;
   logic                  d_req_s;
   logic                  grant_i_s;
   logic                  grant_d_s;
   logic                  owner_req_s;
   logic                  deliver_s;
   logic [3:0]            starve_inc_s;

   assign i_req_s      = i_mem_read;
   assign d_req_s      = d_mem_read | d_mem_write;
   assign starve_inc_s = (starve_cnt_r == 4'hF) ? starve_cnt_r : (starve_cnt_r + 4'd1);

   // Arbitration decision and "owner still wants it" view of the current state
   always_comb begin
      grant_i_s   = 1'b0;
      grant_d_s   = 1'b0;
      owner_req_s = 1'b1;
      case (state_r)
         ST_IDLE: begin
            if (i_req_s && (!d_req_s || (starve_cnt_r == STARVE_MAX))) begin
               grant_i_s = 1'b1;
            end else begin
               grant_i_s = 1'b0;
            end
            grant_d_s = d_req_s && !grant_i_s;
         end
         ST_I_BUSY: owner_req_s = i_req_s;
         ST_D_BUSY: owner_req_s = d_req_s;
         default:   owner_req_s = 1'b1;
      endcase
   end

   // A completion is delivered only if the owner never withdrew; a withdrawal
   // in the completion cycle itself counts as a redirect too.
   assign deliver_s   = pmem_resp && squash_r == 1'b0 && owner_req_s;
   assign i_mem_resp  = deliver_s && (state_r == ST_I_BUSY);
   assign d_mem_resp  = deliver_s && (state_r == ST_D_BUSY);
   assign i_mem_rdata = i_mem_resp ? pmem_rdata : {DATA_WIDTH{1'b0}};
   assign d_mem_rdata = d_mem_resp ? pmem_rdata : {DATA_WIDTH{1'b0}};

   assign pmem_read    = pmem_read_r;
   assign pmem_write   = pmem_write_r;
   assign pmem_address = pmem_address_r;
   assign pmem_wdata   = pmem_wdata_r;
   assign pmem_wmask   = pmem_wmask_r;

   // State, starvation counter, squash flag and registered pmem fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         starve_cnt_r   <= 4'd0;
         squash_r       <= 1'b0;
         pmem_read_r    <= 1'b0;
         pmem_write_r   <= 1'b0;
         pmem_address_r <= {ADDR_WIDTH{1'b0}};
         pmem_wdata_r   <= {DATA_WIDTH{1'b0}};
         pmem_wmask_r   <= {MW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_i_s) begin
                  state_r        <= ST_I_BUSY;
                  starve_cnt_r   <= 4'd0;
                  pmem_read_r    <= 1'b1;
                  pmem_write_r   <= 1'b0;
                  pmem_address_r <= i_mem_address;
                  pmem_wdata_r   <= {DATA_WIDTH{1'b0}};
                  pmem_wmask_r   <= {MW{1'b0}};
               end else if (grant_d_s) begin
                  state_r        <= ST_D_BUSY;
                  // Only a D grant that overtakes a waiting fetch counts.
                  starve_cnt_r   <= i_req_s ? starve_inc_s : 4'd0;
                  // An illegal read+write request is treated as a write.
                  pmem_read_r    <= ~d_mem_write;
                  pmem_write_r   <= d_mem_write;
                  pmem_address_r <= d_mem_address;
                  pmem_wdata_r   <= d_mem_write ? d_mem_wdata : {DATA_WIDTH{1'b0}};
                  pmem_wmask_r   <= d_mem_write ? d_mem_wmask : {MW{1'b0}};
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_I_BUSY, ST_D_BUSY: begin
               if (pmem_resp) begin
                  state_r      <= ST_TURN;
                  squash_r     <= 1'b0;
                  pmem_read_r  <= 1'b0;
                  pmem_write_r <= 1'b0;
               end else if (!owner_req_s) begin
                  squash_r <= 1'b1;
               end else begin
                  squash_r <= squash_r;
               end
            end
            ST_TURN: begin
               state_r  <= ST_IDLE;
               squash_r <= 1'b0;
            end
            default: begin
               state_r      <= ST_IDLE;
               squash_r     <= 1'b0;
               pmem_read_r  <= 1'b0;
               pmem_write_r <= 1'b0;
            end
         endcase
      end
   end

   mem_arbiter_checker u_checker (
      .clk         (clk),
      .rst_n       (rst_n),
      .d_mem_read  (d_mem_read),
      .d_mem_write (d_mem_write)
   );

endmodule

// -----------------------------------------------------------------------------
// mem_arbiter_checker
//   Flags the illegal simultaneous data read and write request.
// Ports
//   clk, rst_n                clock and reset of the arbiter
//   d_mem_read, d_mem_write   data request strobes
// -----------------------------------------------------------------------------
module mem_arbiter_checker (
   input logic clk,
   input logic rst_n,
   input logic d_mem_read,
   input logic d_mem_write
);

   a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      !(d_mem_read && d_mem_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Pipeline-side drivers push expected responses into queues when they issue
//   a request; a monitor pops and compares on every *_resp pulse. A memory
//   responder answers pmem strobes with random or fixed latency from a
//   physical memory array, while a shadow array holds the expected contents.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int MW    = 2;
   localparam int LIMIT = 4;

   typedef struct packed {
      logic          is_wr;
      logic [DW-1:0] data;
   } d_exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          i_mem_read = 1'b0;
   logic [AW-1:0] i_mem_address = '0;
   logic [DW-1:0] i_mem_rdata;
   logic          i_mem_resp;
   logic          d_mem_read = 1'b0;
   logic          d_mem_write = 1'b0;
   logic [AW-1:0] d_mem_address = '0;
   logic [DW-1:0] d_mem_wdata = '0;
   logic [MW-1:0] d_mem_wmask = '0;
   logic [DW-1:0] d_mem_rdata;
   logic          d_mem_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [AW-1:0] pmem_address;
   logic [DW-1:0] pmem_wdata;
   logic [MW-1:0] pmem_wmask;
   logic [DW-1:0] pmem_rdata = '0;
   logic          pmem_resp = 1'b0;

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] phys_mem [256];
   logic [DW-1:0] shadow   [256];
   logic [DW-1:0] i_exp_q  [$];
   d_exp_t        d_exp_q  [$];
   int            resp_log [$];

   int fixed_lat  = -1;
   int stray_cnt  = 0;
   int stray_done = 0;
   int rst_events = 0;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_mem_read    (i_mem_read),
      .i_mem_address (i_mem_address),
      .i_mem_rdata   (i_mem_rdata),
      .i_mem_resp    (i_mem_resp),
      .d_mem_read    (d_mem_read),
      .d_mem_write   (d_mem_write),
      .d_mem_address (d_mem_address),
      .d_mem_wdata   (d_mem_wdata),
      .d_mem_wmask   (d_mem_wmask),
      .d_mem_rdata   (d_mem_rdata),
      .d_mem_resp    (d_mem_resp),
      .pmem_read     (pmem_read),
      .pmem_write    (pmem_write),
      .pmem_address  (pmem_address),
      .pmem_wdata    (pmem_wdata),
      .pmem_wmask    (pmem_wmask),
      .pmem_rdata    (pmem_rdata),
      .pmem_resp     (pmem_resp)
   );

   always #5 clk = ~clk;

   always @(negedge rst_n) rst_events++;

   function automatic int idx(input logic [AW-1:0] a);
      return int'(a[8:1]);
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                           input logic [MW-1:0] wm);
      return {wm[1] ? wd[15:8] : old[15:8], wm[0] ? wd[7:0] : old[7:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every response pulse consumes one expectation.
   initial begin
      d_exp_t e;
      forever begin
         @(negedge clk);
         if (i_mem_resp) begin
            if (i_exp_q.size() == 0) check("i_resp_unexpected", i_mem_resp, 1'b0);
            else check("i_rdata", i_mem_rdata, i_exp_q.pop_front());
            resp_log.push_back(0);
         end
         if (d_mem_resp) begin
            if (d_exp_q.size() == 0) check("d_resp_unexpected", d_mem_resp, 1'b0);
            else begin
               e = d_exp_q.pop_front();
               if (!e.is_wr) check("d_rdata", d_mem_rdata, e.data);
            end
            resp_log.push_back(1);
         end
      end
   end

   // Physical memory responder.
   initial begin
      logic [AW-1:0] c_addr;
      logic [DW-1:0] c_wdata;
      logic [MW-1:0] c_wmask;
      logic          c_wr;
      int            lat;
      int            c_rst;
      forever begin
         @(negedge clk);
         if (rst_n && (pmem_read || pmem_write)) begin
            c_addr  = pmem_address;
            c_wdata = pmem_wdata;
            c_wmask = pmem_wmask;
            c_wr    = pmem_write;
            c_rst   = rst_events;
            lat     = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            repeat (lat) @(negedge clk);
            @(posedge clk);
            #1;
            if (c_rst == rst_events) begin
               check("pmem_addr_stable", pmem_address, c_addr);
               check("pmem_strobe_stable", {pmem_read, pmem_write}, {~c_wr, c_wr});
               if (c_wr) phys_mem[idx(c_addr)] = merge(phys_mem[idx(c_addr)], c_wdata, c_wmask);
            end
            pmem_resp  = 1'b1;
            pmem_rdata = c_wr ? DW'($urandom) : phys_mem[idx(c_addr)];
            @(posedge clk);
            #1;
            pmem_resp  = 1'b0;
            pmem_rdata = DW'($urandom);
         end else if (stray_cnt != stray_done) begin
            stray_done++;
            @(posedge clk);
            #1;
            pmem_resp = 1'b1;
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
         end
      end
   end

   task automatic do_i(input logic [AW-1:0] addr, output int lat);
      i_exp_q.push_back(shadow[idx(addr)]);
      i_mem_address = addr;
      i_mem_read    = 1'b1;
      lat = -1;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (i_mem_resp) begin
            lat = n - 1;
            break;
         end
      end
      if (lat < 0) begin
         check("i_resp_timeout", i_mem_resp, 1'b1);
         void'(i_exp_q.pop_back());
      end
      @(posedge clk);
      #1;
      i_mem_read = 1'b0;
   endtask

   task automatic do_d(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [MW-1:0] wm);
      d_exp_t e;
      bit     got = 1'b0;
      e.is_wr = wr;
      e.data  = shadow[idx(addr)];
      if (wr) shadow[idx(addr)] = merge(shadow[idx(addr)], wd, wm);
      d_exp_q.push_back(e);
      d_mem_address = addr;
      d_mem_wdata   = wd;
      d_mem_wmask   = wm;
      d_mem_read    = ~wr;
      d_mem_write   = wr;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (d_mem_resp) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         check("d_resp_timeout", d_mem_resp, 1'b1);
         void'(d_exp_q.pop_back());
      end
      @(posedge clk);
      #1;
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
   endtask

   task automatic watch_pmem(input string tag, input logic rd, input logic wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [MW-1:0] wm);
      int n = 0;
      while (!(pmem_read || pmem_write) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!(pmem_read || pmem_write)) check({tag, "_strobe_timeout"}, pmem_read | pmem_write, 1'b1);
      else begin
         check({tag, "_strobes"}, {pmem_read, pmem_write}, {rd, wr});
         check({tag, "_addr"}, pmem_address, a);
         check({tag, "_wdata"}, pmem_wdata, wd);
         check({tag, "_wmask"}, pmem_wmask, wm);
      end
   endtask

   task automatic i_stream(input int n);
      int lat;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         do_i({7'($urandom), 1'b0, 7'($urandom), 1'b0}, lat);
      end
   endtask

   task automatic d_stream(input int n);
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         do_d(1'($urandom), {7'($urandom), 1'b1, 7'($urandom), 1'b0}, DW'($urandom), MW'($urandom));
      end
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      i_mem_read  = 1'b0;
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pmem_read"},  pmem_read, 1'b0);
      check({tag, "_pmem_write"}, pmem_write, 1'b0);
      check({tag, "_pmem_addr"},  pmem_address, 16'h0000);
      check({tag, "_pmem_wdata"}, pmem_wdata, 16'h0000);
      check({tag, "_pmem_wmask"}, pmem_wmask, 2'b00);
      check({tag, "_i_resp"},     i_mem_resp, 1'b0);
      check({tag, "_d_resp"},     d_mem_resp, 1'b0);
   endtask

   task automatic wait_stray_pulse(input string tag);
      int n = 0;
      while (!pmem_resp && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!pmem_resp) check({tag, "_pulse_timeout"}, pmem_resp, 1'b1);
      else begin
         check({tag, "_i_resp"}, i_mem_resp, 1'b0);
         check({tag, "_d_resp"}, d_mem_resp, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      int  n;
      for (int i = 0; i < 256; i++) begin
         phys_mem[i] = DW'($urandom);
         shadow[i]   = phys_mem[i];
      end

      // Reset values
      #1 rst_n = 1'b0;
      #1 check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // I only, fetch data 0x1234, pmem_resp three cycles after the strobe
      phys_mem[idx(16'h0010)] = 16'h1234;
      shadow[idx(16'h0010)]   = 16'h1234;
      fixed_lat = 2;
      fork
         do_i(16'h0010, lat);
         watch_pmem("i_fetch", 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);
      join
      check("i_fetch_latency", lat, 4);
      check("i_fetch_turn_strobes", {pmem_read, pmem_write}, 2'b00);

      // Minimum latency
      fixed_lat = 0;
      @(posedge clk);
      #1;
      do_i(16'h0022, lat);
      check("min_latency", lat, 2);

      // D write with byte mask, then read back the merged word
      fixed_lat = 1;
      @(posedge clk);
      #1;
      fork
         do_d(1'b1, 16'h0200, 16'hBEEF, 2'b10);
         watch_pmem("d_write", 1'b0, 1'b1, 16'h0200, 16'hBEEF, 2'b10);
      join
      do_d(1'b0, 16'h0200, 16'h0000, 2'b00);

      // Randomized concurrent traffic
      fixed_lat = -1;
      fork
         i_stream(30);
         d_stream(30);
      join

      // Starvation: both held, expect D,D,D,D,I repeating
      do_reset();
      resp_log.delete();
      fork
         for (int k = 0; k < 2; k++) begin
            int l2;
            do_i({8'h00, 7'($urandom), 1'b0}, l2);
         end
         for (int k = 0; k < 8; k++) do_d(1'b0, {7'h00, 1'b1, 7'($urandom), 1'b0}, 16'h0000, 2'b00);
      join
      check("starve_resp_count", resp_log.size(), 10);
      for (int k = 0; k < resp_log.size() && k < 10; k++)
         check($sformatf("starve_order_%0d", k), resp_log[k], ((k + 1) % (LIMIT + 1) == 0) ? 0 : 1);

      // Squash: fetch withdrawn after grant, pending D served afterwards
      fixed_lat = 3;
      repeat (2) begin @(posedge clk); #1; end
      fork
         begin
            i_mem_address = 16'h0040;
            i_mem_read    = 1'b1;
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            i_mem_read = 1'b0;
            @(negedge clk);
            check("squash_pmem_read_held", pmem_read, 1'b1);
         end
         begin
            @(posedge clk);
            #1;
            do_d(1'b0, 16'h8120, 16'h0000, 2'b00);
         end
      join

      // Reset during D_BUSY, stray pmem_resp afterwards
      fixed_lat     = 4;
      d_mem_address = 16'h8100;
      d_mem_read    = 1'b1;
      n = 0;
      while (!pmem_read && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_strobe_seen", pmem_read, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst_mid");
      d_mem_read = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_stray_pulse("rst_stray");

      // Stray pmem_resp in IDLE
      repeat (3) begin @(posedge clk); #1; end
      stray_cnt++;
      wait_stray_pulse("idle_stray");
      @(negedge clk);
      check("idle_stray_no_strobe", {pmem_read, pmem_write}, 2'b00);

      repeat (5) @(posedge clk);
      check("i_queue_drained", i_exp_q.size(), 0);
      check("d_queue_drained", d_exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
